// File: rtl/score_ctrl_if.sv
// Game-side bundle for score_ctrl: frame/button/event inputs and the
// score, high-score and state outputs consumed by the renderer.
interface score_ctrl_if;
    logic       i_frame_tick;
    logic       i_move;
    logic       i_collision;
    logic       i_start;
    logic [6:0] o_score;
    logic [6:0] o_high_score;
    logic [1:0] o_state;
    logic       o_new_high;

    modport master (
        output i_frame_tick, i_move, i_collision, i_start,
        input  o_score, o_high_score, o_state, o_new_high
    );

    modport slave (
        input  i_frame_tick, i_move, i_collision, i_start,
        output o_score, o_high_score, o_state, o_new_high
    );
endinterface

// File: rtl/score_ctrl.sv
// Score keeper for a single-player game: counts held-move frames into a
// saturating score, tracks the best score and sequences IDLE/PLAY/DEAD.
module score_ctrl #(
    parameter int MAX_SCORE   = 99,
    parameter int MOVE_FRAMES = 8,
    parameter int DEAD_FRAMES = 60
) (
    input  logic         i_clk,
    input  logic         i_rst,
    score_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10
    } state_e;

    // Terminal counts held in 8 bits so compares never see a wider operand.
    localparam logic [7:0] MOVE_LAST = 8'(MOVE_FRAMES - 1);
    localparam logic [7:0] DEAD_LAST = 8'(DEAD_FRAMES - 1);
    localparam logic [6:0] SCORE_MAX = 7'(MAX_SCORE);

    state_e     state_q, state_d;
    logic [7:0] move_cnt_q, move_cnt_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [6:0] score_q, score_d;
    logic [6:0] high_q, high_d;
    logic       new_high_q, new_high_d;

    // Next-state and counter/score update logic.
    always_comb begin
        state_d     = state_q;
        move_cnt_d  = move_cnt_q;
        frame_cnt_d = frame_cnt_q;
        score_d     = score_q;
        high_d      = high_q;
        new_high_d  = new_high_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d     = ST_PLAY;
                    score_d     = 7'd0;
                    new_high_d  = 1'b0;
                    move_cnt_d  = 8'd0;
                    frame_cnt_d = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                // Collision wins over any increment due on the same edge.
                if (bus.i_collision) begin
                    state_d     = ST_DEAD;
                    move_cnt_d  = 8'd0;
                    frame_cnt_d = 8'd0;
                    if (score_q > high_q) begin
                        high_d     = score_q;
                        new_high_d = 1'b1;
                    end else begin
                        new_high_d = new_high_q;
                    end
                end else if (bus.i_frame_tick) begin
                    if (bus.i_move) begin
                        if (move_cnt_q == MOVE_LAST) begin
                            move_cnt_d = 8'd0;
                            if (score_q < SCORE_MAX) begin
                                score_d = score_q + 7'd1;
                            end else begin
                                score_d = score_q;
                            end
                        end else begin
                            move_cnt_d = move_cnt_q + 8'd1;
                        end
                    end else begin
                        move_cnt_d = 8'd0;
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_DEAD: begin
                if (bus.i_frame_tick) begin
                    if (frame_cnt_q == DEAD_LAST) begin
                        state_d     = ST_IDLE;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end else begin
                    state_d = ST_DEAD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                move_cnt_d  = 8'd0;
                frame_cnt_d = 8'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            move_cnt_q  <= 8'd0;
            frame_cnt_q <= 8'd0;
            score_q     <= 7'd0;
            high_q      <= 7'd0;
            new_high_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            move_cnt_q  <= move_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            score_q     <= score_d;
            high_q      <= high_d;
            new_high_q  <= new_high_d;
        end
    end

    assign bus.o_score      = score_q;
    assign bus.o_high_score = high_q;
    assign bus.o_state      = state_q;
    assign bus.o_new_high   = new_high_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural game model.
module tb_score_ctrl;

    localparam int MAXS = 99;
    localparam int MF   = 8;
    localparam int DF   = 60;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_en = 1'b0;

    score_ctrl_if bus ();

    score_ctrl #(.MAX_SCORE(MAXS), .MOVE_FRAMES(MF), .DEAD_FRAMES(DF)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural model: mode 0 idle, 1 play, 2 dead.
    int m_mode = 0;
    int m_run = 0;
    int m_score = 0;
    int m_high = 0;
    int m_newh = 0;
    int m_dead = 0;

    task automatic model_step(input logic r, input logic s, input logic t,
                              input logic m, input logic c);
        if (r) begin
            m_mode = 0; m_run = 0; m_score = 0; m_high = 0; m_newh = 0; m_dead = 0;
        end else if (m_mode == 0) begin
            if (s) begin
                m_mode = 1; m_score = 0; m_newh = 0; m_run = 0;
            end
        end else if (m_mode == 1) begin
            if (c) begin
                if (m_score > m_high) begin
                    m_high = m_score;
                    m_newh = 1;
                end
                m_mode = 2; m_dead = 0; m_run = 0;
            end else if (t) begin
                if (m) begin
                    m_run = m_run + 1;
                    if ((m_run % MF) == 0 && m_score < MAXS) m_score = m_score + 1;
                end else begin
                    m_run = 0;
                end
            end
        end else begin
            if (t) begin
                m_dead = m_dead + 1;
                if (m_dead == DF) m_mode = 0;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge i_clk) begin
        if (cmp_en) begin
            checks = checks + 4;
            if (int'(bus.o_state) != m_mode) begin
                failures = failures + 1;
                $display("FAIL cyc_state t=%0t got=%0d exp=%0d", $time, bus.o_state, m_mode);
            end
            if (int'(bus.o_score) != m_score) begin
                failures = failures + 1;
                $display("FAIL cyc_score t=%0t got=%0d exp=%0d", $time, bus.o_score, m_score);
            end
            if (int'(bus.o_high_score) != m_high) begin
                failures = failures + 1;
                $display("FAIL cyc_high t=%0t got=%0d exp=%0d", $time, bus.o_high_score, m_high);
            end
            if (int'(bus.o_new_high) != m_newh) begin
                failures = failures + 1;
                $display("FAIL cyc_newhigh t=%0t got=%0d exp=%0d", $time, bus.o_new_high, m_newh);
            end
        end
    end

    task automatic cyc(input logic r, input logic s, input logic t,
                       input logic m, input logic c);
        i_rst            = r;
        bus.i_start      = s;
        bus.i_frame_tick = t;
        bus.i_move       = m;
        bus.i_collision  = c;
        @(posedge i_clk);
        model_step(r, s, t, m, c);
        @(negedge i_clk);
    endtask

    // One frame tick followed by a gap cycle where the move level wanders.
    task automatic tick(input logic m);
        cyc(1'b0, 1'b0, 1'b1, m, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic held(input int n);
        for (int k = 0; k < n; k++) tick(1'b1);
    endtask

    task automatic dead_out();
        for (int k = 0; k < DF; k++) tick(1'($urandom_range(0, 1)));
    endtask

    task automatic start_game();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic collide();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pin(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    initial begin
        bus.i_start = 1'b0; bus.i_frame_tick = 1'b0;
        bus.i_move = 1'b0; bus.i_collision = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        pin("reset_state", int'(bus.o_state), 0);
        pin("reset_score", int'(bus.o_score), 0);
        pin("reset_high", int'(bus.o_high_score), 0);
        pin("reset_newhigh", int'(bus.o_new_high), 0);

        // 24 held ticks score 3.
        start_game();
        pin("start_state", int'(bus.o_state), 1);
        held(24);
        pin("held24_score", int'(bus.o_score), 3);
        pin("held24_state", int'(bus.o_state), 1);
        collide();
        pin("end3_high", int'(bus.o_high_score), 3);
        pin("end3_newhigh", int'(bus.o_new_high), 1);
        pin("end3_state", int'(bus.o_state), 2);
        dead_out();
        pin("dead_done_state", int'(bus.o_state), 0);
        pin("idle_hold_score", int'(bus.o_score), 3);

        // Released tick discards partial progress.
        start_game();
        pin("restart_score", int'(bus.o_score), 0);
        pin("restart_newhigh", int'(bus.o_new_high), 0);
        held(7); tick(1'b0); held(7);
        pin("partial_score", int'(bus.o_score), 0);

        // Collision on the 8th held tick beats the increment; start in DEAD ignored.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        pin("coll_prio_score", int'(bus.o_score), 0);
        pin("coll_prio_state", int'(bus.o_state), 2);
        start_game();
        pin("dead_start_ign", int'(bus.o_state), 2);
        dead_out();

        // Two games ending at 5: only the first sets a new high.
        start_game(); held(40); collide();
        pin("g5a_high", int'(bus.o_high_score), 5);
        pin("g5a_newhigh", int'(bus.o_new_high), 1);
        dead_out();
        start_game(); held(40); collide();
        pin("g5b_newhigh", int'(bus.o_new_high), 0);
        pin("g5b_high", int'(bus.o_high_score), 5);
        dead_out();
        pin("g5b_idle_state", int'(bus.o_state), 0);
        pin("g5b_idle_score", int'(bus.o_score), 5);

        // Saturation at MAX_SCORE, idle start+collision enters PLAY.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        pin("start_coll_state", int'(bus.o_state), 1);
        held(810);
        pin("sat_score", int'(bus.o_score), 99);
        collide();
        pin("sat_high", int'(bus.o_high_score), 99);
        pin("sat_newhigh", int'(bus.o_new_high), 1);
        pin("sat_state", int'(bus.o_state), 2);
        dead_out();

        // Reset mid-PLAY with score 12, high 30.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        start_game(); held(240); collide(); dead_out();
        start_game(); held(96);
        pin("pre_rst_score", int'(bus.o_score), 12);
        pin("pre_rst_high", int'(bus.o_high_score), 30);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        pin("rst_score", int'(bus.o_score), 0);
        pin("rst_high", int'(bus.o_high_score), 0);
        pin("rst_state", int'(bus.o_state), 0);
        start_game();
        pin("post_rst_start", int'(bus.o_state), 1);

        // Randomized traffic checked against the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            cyc(1'($urandom_range(0, 499) == 0),
                1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 9) < 8),
                1'($urandom_range(0, 99) == 0));
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 Parameter MAX_SCORE, default 99; saturation value of the score, range 1..99.
REQ-002 Parameter MOVE_FRAMES, default 8; held-move frame ticks per score increment, range 1..255.
REQ-003 Parameter DEAD_FRAMES, default 60; frame ticks spent in DEAD before returning to IDLE, range 1..255.
REQ-004 i_clk  input  1  single clock; all logic rising-edge triggered.
REQ-005 i_rst  input  1  reset; synchronous, active-high.
REQ-006 i_frame_tick  input  1  one-cycle pulse per video frame, at vsync.
REQ-007 i_move  input  1  move button level, already synchronised and debounced.
REQ-008 i_collision  input  1  one-cycle pulse when the player is hit.
REQ-009 i_start  input  1  one-cycle pulse requesting a new game.
REQ-010 o_score  output  7  current score, 0..MAX_SCORE, for the score renderer.
REQ-011 o_high_score  output  7  best score since reset, 0..MAX_SCORE.
REQ-012 o_state  output  2  state: 00 IDLE, 01 PLAY, 10 DEAD; 11 is never driven.
REQ-013 o_new_high  output  1  high when the last completed game set a new high score.

Function
REQ-014 The FSM SHALL have the states IDLE, PLAY and DEAD, all registered.
REQ-015 IDLE->PLAY on i_start; same edge: o_score<=0, o_new_high<=0, frame counter<=0.
REQ-016 In PLAY, on each i_frame_tick with i_move=1, the move counter SHALL increment.
REQ-017 When the move counter reaches MOVE_FRAMES-1 and a qualifying tick arrives, the counter SHALL wrap to 0 and o_score SHALL increment by 1. First increment occurs on the MOVE_FRAMES-th held tick.
REQ-018 o_score SHALL saturate at MAX_SCORE; further qualifying ticks leave it unchanged and never wrap.
REQ-019 On i_frame_tick with i_move=0 in PLAY, the move counter SHALL clear to 0 (partial progress discarded).
REQ-020 Ticks without i_frame_tick SHALL NOT affect the counters; i_move changes between ticks are ignored.
REQ-021 PLAY->DEAD on i_collision; collision SHALL take priority over a same-cycle increment (score not incremented that cycle).
REQ-022 On the PLAY->DEAD edge, if o_score > o_high_score then o_high_score<=o_score and o_new_high<=1; equal scores SHALL NOT set o_new_high.
REQ-023 In DEAD, the frame counter SHALL count i_frame_tick; after DEAD_FRAMES ticks the FSM SHALL go to IDLE on that tick's edge.
REQ-024 In DEAD, o_score SHALL hold the final value; in IDLE, o_score and o_new_high SHALL hold until the next i_start.
REQ-025 i_start in PLAY or DEAD SHALL be ignored; i_collision in IDLE or DEAD SHALL be ignored.
REQ-026 If i_start and i_collision arrive in the same cycle in IDLE, the FSM SHALL enter PLAY (collision ignored).
REQ-027 All outputs SHALL be registered; every response appears one clock after the causing input edge.
REQ-028 Counter widths SHALL be 8 bits; compare logic SHALL NOT overflow for maximum parameter values.

Reset
REQ-029 With i_rst=1 at a clock edge: state<=IDLE, o_score<=0, o_high_score<=0, o_new_high<=0, counters<=0.
REQ-030 Reset SHALL take priority over every other input, including mid-PLAY and mid-DEAD; the high score is lost.
REQ-031 After reset deassertion, the first i_start SHALL be accepted on the first edge with i_rst=0.

Verification
REQ-032 Default parameters; i_start, i_move=1, 24 frame ticks -> o_score=3, o_state=01.
REQ-033 i_move=1 for 7 ticks, i_move=0 on the 8th tick, i_move=1 for 7 more ticks -> o_score stays 0.
REQ-034 MAX_SCORE=99; hold move for 800+ ticks -> o_score=99, no wrap; collision -> o_high_score=99, o_new_high=1, o_state=10.
REQ-035 Game ends at 5 with high score 5; next game ends at 5 -> o_new_high=0, o_high_score=5; 60 ticks later -> o_state=00, o_score=5.
REQ-036 Collision coincident with the 8th held tick -> o_score unchanged, o_state=10; i_start during DEAD -> ignored.
REQ-037 i_rst pulse mid-PLAY with score 12 and high score 30 -> next cycle o_score=0, o_high_score=0, o_state=00.
